// File: rtl/l1c_inst_sa.sv
// ---------------------------------------------------------------------------
// l1c_inst_sa -- N-way set-associative L1 instruction cache.
//
// Sits between the CPU fetch port and the instruction-side memory master.
// Cached reads hit in the same cycle. A miss refills the whole line,
// critical word first, wrapping around the line. Writes and reads of the
// volatile region are passed through as single-beat transfers and never
// touch the arrays.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   core_req        core access request; the request fields are held while
//                   core_wait=1
//   core_addr       byte address
//   core_write      write access (always a pass-through)
//   core_in         write data
//   core_type       access size (BYTE/HWORD/WORD/BYTE_U/HWORD_U)
//   core_out        read data, valid when core_req=1 and core_wait=0
//   core_wait       stall to the core
//   flush           single-cycle pulse; invalidates every line
//   I_req .. I_type memory beat request, address, write, data, size
//   I_out, I_wait   memory read data and stall; a beat completes when
//                   I_req=1 and I_wait=0
//   hit_cnt         cached read hits (saturating)
//   miss_cnt        cached read misses (saturating)
//
// Handshake: the core side completes a request in the cycle where
// core_req=1 and core_wait=0. The memory side completes a beat in the cycle
// where I_req=1 and I_wait=0. Neither side may change its request fields
// while the request is still pending.
// ---------------------------------------------------------------------------
module l1c_inst_sa #(
    parameter int          WAYS       = 2,
    parameter int          SETS       = 32,
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] VOL_BASE   = 32'h1000_0000,
    parameter logic [31:0] VOL_MASK   = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    input  logic        core_write,
    input  logic [31:0] core_in,
    input  logic [2:0]  core_type,
    output logic [31:0] core_out,
    output logic        core_wait,
    input  logic        flush,
    output logic        I_req,
    output logic [31:0] I_addr,
    output logic        I_write,
    output logic [31:0] I_in,
    output logic [2:0]  I_type,
    input  logic [31:0] I_out,
    input  logic        I_wait,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] CACHE_BYTE    = 3'd0;
    localparam logic [2:0] CACHE_HWORD   = 3'd1;
    localparam logic [2:0] CACHE_WORD    = 3'd2;
    localparam logic [2:0] CACHE_BYTE_U  = 3'd4;
    localparam logic [2:0] CACHE_HWORD_U = 3'd5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REFILL = 3'd1;
    localparam logic [2:0] S_DONE   = 3'd2;
    localparam logic [2:0] S_BYPASS = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    // Storage
    logic [SETS-1:0]  valid_q [WAYS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
    logic [WAY_W-1:0] rr_q    [SETS];

    // Control state
    logic [2:0]              state_q, state_d;
    logic                    flush_pend_q;
    logic [TAG_W+IDX_W-1:0]  line_q;      // tag+index of the line being refilled
    logic [WORD_W-1:0]       crit_q;      // requested (critical) word
    logic [WORD_W-1:0]       beat_q;      // completed refill beats
    logic [WAY_W-1:0]        victim_q;
    logic [31:0]             out_reg_q;
    logic [31:0]             hit_cnt_q, miss_cnt_q;

    // Request decode
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              vol;
    logic              cached_rd;

    assign req_tag   = core_addr[31 -: TAG_W];
    assign req_idx   = core_addr[OFF_W +: IDX_W];
    assign req_word  = core_addr[2 +: WORD_W];
    assign vol       = ((core_addr & VOL_MASK) == VOL_BASE);
    assign cached_rd = !core_write && !vol;

    // Lookup and victim selection
    logic             hit, has_inv;
    logic [WAY_W-1:0] hit_way, inv_way, victim;
    logic [31:0]      hit_data;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!has_inv && !valid_q[w][req_idx]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign victim   = has_inv ? inv_way : rr_q[req_idx];
    assign hit_data = data_q[hit_way][req_idx][req_word];

    // Refill bookkeeping
    logic [IDX_W-1:0]  line_idx;
    logic [TAG_W-1:0]  line_tag;
    logic [WORD_W-1:0] beat_word;
    logic              last_beat;
    logic              beat_done;
    logic              refill_beat;
    logic              install;
    logic [WAY_W-1:0]  rr_next;

    assign line_idx    = line_q[IDX_W-1:0];
    assign line_tag    = line_q[TAG_W+IDX_W-1 -: TAG_W];
    assign beat_word   = crit_q + beat_q;              // wraps inside the line
    assign last_beat   = (beat_q == WORD_W'(LINE_WORDS - 1));
    assign beat_done   = I_req && !I_wait;
    assign refill_beat = (state_q == S_REFILL) && beat_done;
    // A flush seen at any point during the refill keeps the line invalid.
    assign install     = refill_beat && last_beat && !flush && !flush_pend_q;
    assign rr_next     = (rr_q[line_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[line_idx] + 1'b1;

    // Write data is placed on the byte lanes it addresses.
    logic [31:0] wdata_aligned;

    always_comb begin
        wdata_aligned = core_in;
        case (core_type)
            CACHE_BYTE, CACHE_BYTE_U:
                wdata_aligned = {24'b0, core_in[7:0]} << {core_addr[1:0], 3'b000};
            CACHE_HWORD, CACHE_HWORD_U:
                wdata_aligned = {16'b0, core_in[15:0]} << {core_addr[1], 4'b0000};
            default: ;
        endcase
    end

    // Next state and outputs
    logic do_hit, do_miss;

    always_comb begin
        state_d   = state_q;
        core_wait = 1'b0;
        core_out  = '0;
        I_req     = 1'b0;
        I_addr    = '0;
        I_write   = 1'b0;
        I_in      = '0;
        I_type    = '0;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        // Outputs are forced idle for the whole time reset is held.
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        // Flush wins over a request in the same cycle.
                        core_wait = core_req;
                        state_d   = S_FLUSH;
                    end else if (core_req) begin
                        if (cached_rd) begin
                            if (hit) begin
                                core_out = hit_data;
                                do_hit   = 1'b1;
                            end else begin
                                core_wait = 1'b1;
                                do_miss   = 1'b1;
                                state_d   = S_REFILL;
                            end
                        end else begin
                            core_wait = 1'b1;
                            state_d   = S_BYPASS;
                        end
                    end
                end
                S_REFILL: begin
                    core_wait = 1'b1;
                    I_req     = 1'b1;
                    I_type    = CACHE_WORD;
                    I_addr    = {line_q, beat_word, 2'b00};
                    if (beat_done && last_beat) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    core_out = out_reg_q;
                    state_d  = (flush || flush_pend_q) ? S_FLUSH : S_IDLE;
                end
                S_BYPASS: begin
                    I_req     = 1'b1;
                    I_addr    = core_addr;
                    I_write   = core_write;
                    I_type    = core_type;
                    I_in      = core_write ? wdata_aligned : '0;
                    core_wait = 1'b1;
                    if (!I_wait) begin
                        core_wait = 1'b0;
                        core_out  = core_write ? '0 : I_out;
                        state_d   = (flush || flush_pend_q) ? S_FLUSH : S_IDLE;
                    end
                end
                S_FLUSH: begin
                    core_wait = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control registers, valid bits, replacement pointers, counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
            line_q       <= '0;
            crit_q       <= '0;
            beat_q       <= '0;
            victim_q     <= '0;
            out_reg_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == S_FLUSH) begin
                flush_pend_q <= 1'b0;
                for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            end else if (flush && (state_q != S_IDLE)) begin
                flush_pend_q <= 1'b1;
            end

            if (do_miss) begin
                line_q   <= core_addr[31:OFF_W];
                crit_q   <= req_word;
                victim_q <= victim;
                beat_q   <= '0;
            end

            if (refill_beat) begin
                beat_q <= beat_q + 1'b1;
                if (beat_q == '0) out_reg_q <= I_out;
            end

            if (install) begin
                valid_q[victim_q][line_idx] <= 1'b1;
                rr_q[line_idx]              <= rr_next;
            end

            if (do_hit && (hit_cnt_q != 32'hFFFF_FFFF))  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (do_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (refill_beat) data_q[victim_q][line_idx][beat_word] <= I_out;
        if (install)     tag_q[victim_q][line_idx] <= line_tag;
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_l1c_inst_sa.sv
// ---------------------------------------------------------------------------
// Testbench for l1c_inst_sa. A fixed-content memory answers the refill and
// bypass beats. A line-level model of the cache (line numbers per set, valid
// flags, round-robin pointer) predicts hit/miss and the counters. Directed
// steps come first, followed by a randomized mix of cached reads, volatile
// reads, writes and flushes under random memory stalls.
// ---------------------------------------------------------------------------
module tb_l1c_inst_sa;
  localparam int WAYS       = 2;
  localparam int SETS       = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;
  localparam logic [2:0] T_BYTE  = 3'd0;
  localparam logic [2:0] T_HWORD = 3'd1;
  localparam logic [2:0] T_WORD  = 3'd2;
  localparam int TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        core_req = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_write = 1'b0;
  logic [31:0] core_in = '0;
  logic [2:0]  core_type = T_WORD;
  logic [31:0] core_out;
  logic        core_wait;
  logic        flush = 1'b0;
  logic        I_req;
  logic [31:0] I_addr;
  logic        I_write;
  logic [31:0] I_in;
  logic [2:0]  I_type;
  logic [31:0] I_out;
  logic        I_wait;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  l1c_inst_sa #(
    .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS),
    .VOL_BASE(32'h1000_0000), .VOL_MASK(32'hF000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_addr(core_addr), .core_write(core_write),
    .core_in(core_in), .core_type(core_type), .core_out(core_out),
    .core_wait(core_wait), .flush(flush),
    .I_req(I_req), .I_addr(I_addr), .I_write(I_write), .I_in(I_in),
    .I_type(I_type), .I_out(I_out), .I_wait(I_wait),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // ---------------- memory responder ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign I_out = mem_word(I_addr);

  int   wait_cnt = 0;
  int   stall_until = 0;
  logic rand_wait = 1'b0;
  bit   rand_en = 1'b0;

  assign I_wait = (wait_cnt < stall_until) || rand_wait;
  always @(posedge clk) if (I_req && (wait_cnt < stall_until)) wait_cnt <= wait_cnt + 1;
  always @(negedge clk) rand_wait = rand_en ? ($urandom_range(0, 3) == 0) : 1'b0;

  // Completed memory beats, recorded mid-cycle.
  logic [31:0] bt_addr[$];
  logic [31:0] bt_in[$];
  logic        bt_wr[$];
  logic [2:0]  bt_type[$];
  always @(negedge clk) begin
    #3;
    if (I_req === 1'b1 && I_wait === 1'b0) begin
      bt_addr.push_back(I_addr);
      bt_in.push_back(I_in);
      bt_wr.push_back(I_write);
      bt_type.push_back(I_type);
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_line  [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  int          m_rr    [SETS];
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic void model_reset();
    model_flush();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic bit model_access(input logic [31:0] a, input bit may_install);
    logic [31:0] line;
    int set;
    int victim;
    line = a / LINE_BYTES;
    set = int'(line % SETS);
    victim = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set][w] && m_line[set][w] == line) begin
        m_hits++;
        return 1'b1;
      end
    m_misses++;
    if (may_install) begin
      for (int w = 0; w < WAYS; w++)
        if (victim < 0 && !m_valid[set][w]) victim = w;
      if (victim < 0) victim = m_rr[set];
      m_valid[set][victim] = 1'b1;
      m_line[set][victim] = line;
      m_rr[set] = (m_rr[set] + 1) % WAYS;
    end
    return 1'b0;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One core access. flush_at: cycle (0 = request cycle) in which to pulse
  // flush, negative for none. stalls = cycles with core_wait=1.
  task automatic access(input logic [31:0] a, input logic wr, input logic [2:0] ty,
                        input logic [31:0] wd, input int flush_at,
                        output int stalls, output logic [31:0] rdata, output int base);
    int n;
    n = 0;
    @(negedge clk);
    base = bt_addr.size();
    core_req = 1'b1; core_addr = a; core_write = wr; core_type = ty; core_in = wd;
    flush = (flush_at == 0);
    #1;
    while (core_wait === 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      flush = (n == flush_at);
      #1;
    end
    stalls = n;
    rdata = core_out;
    if (n >= TIMEOUT) check("access_timeout", {31'b0, core_wait}, 32'd0);
    @(posedge clk);
    #1;
    core_req = 1'b0; core_write = 1'b0; flush = 1'b0;
  endtask

  task automatic cached_read(input logic [31:0] a, input int flush_at, input bit exact);
    bit exp_hit;
    int stalls, base, exp_stalls;
    logic [31:0] rd, exp_a;
    if (flush_at == 0) model_flush();
    exp_hit = model_access(a, flush_at <= 0);
    access(a, 1'b0, T_WORD, 32'd0, flush_at, stalls, rd, base);
    if (flush_at > 0) model_flush();
    check("rd_data", rd, mem_word(a));
    exp_stalls = exp_hit ? 0 : (LINE_WORDS + 1 + ((flush_at == 0) ? 2 : 0));
    if (exact || exp_hit) check("rd_stalls", stalls, exp_stalls);
    else check("rd_stalls_min", {31'b0, stalls >= exp_stalls}, 32'd1);
    check("rd_beats", bt_addr.size() - base, exp_hit ? 0 : LINE_WORDS);
    if (!exp_hit && bt_addr.size() - base == LINE_WORDS) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        exp_a = (a & ~32'(LINE_BYTES - 1)) | (32'(((a / 4) + k) % LINE_WORDS) * 4);
        check("refill_addr", bt_addr[base + k], exp_a);
        check("refill_type", {29'b0, bt_type[base + k]}, {29'b0, T_WORD});
      end
    end
  endtask

  function automatic logic [31:0] lane_align(input logic [31:0] a, input logic [2:0] ty,
                                              input logic [31:0] wd);
    case (ty)
      T_BYTE:  return 32'(wd[7:0]) << (8 * a[1:0]);
      T_HWORD: return 32'(wd[15:0]) << (16 * a[1]);
      default: return wd;
    endcase
  endfunction

  task automatic bypass(input logic [31:0] a, input logic wr, input logic [2:0] ty,
                        input logic [31:0] wd, input int exp_stalls);
    int stalls, base;
    logic [31:0] rd;
    access(a, wr, ty, wd, -1, stalls, rd, base);
    if (exp_stalls >= 0) check("bp_stalls", stalls, exp_stalls);
    check("bp_beats", bt_addr.size() - base, 1);
    if (bt_addr.size() - base == 1) begin
      check("bp_addr", bt_addr[base], a);
      check("bp_write", {31'b0, bt_wr[base]}, {31'b0, wr});
      check("bp_type", {29'b0, bt_type[base]}, {29'b0, ty});
      if (wr) check("bp_wdata", bt_in[base], lane_align(a, ty, wd));
    end
    if (!wr) check("bp_rdata", rd, mem_word(a));
  endtask

  task automatic check_counters();
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
  endtask

  function automatic logic [31:0] rand_cached_addr();
    return (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, LINE_WORDS - 1)) << 2);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_core_wait", {31'b0, core_wait}, 32'd0);
    check("rst_core_out", core_out, 32'd0);
    check("rst_I_req", {31'b0, I_req}, 32'd0);
    check("rst_I_addr", I_addr, 32'd0);
    check("rst_I_write", {31'b0, I_write}, 32'd0);
    check("rst_I_in", I_in, 32'd0);
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Cold read, critical word first
    cached_read(32'h0000_0108, -1, 1'b1);
    check_counters();

    // Rereads of the same line hit
    cached_read(32'h0000_0100, -1, 1'b1);
    cached_read(32'h0000_010C, -1, 1'b1);
    check_counters();

    // Same-set fills and round-robin eviction
    cached_read(32'h0000_0000, -1, 1'b1);
    cached_read(32'h0000_0800, -1, 1'b1);
    cached_read(32'h0000_1000, -1, 1'b1);
    cached_read(32'h0000_0800, -1, 1'b1);
    cached_read(32'h0000_0000, -1, 1'b1);
    check_counters();

    // Volatile read with three stalled beat cycles
    stall_until = wait_cnt + 3;
    bypass(32'h1000_0004, 1'b0, T_WORD, 32'd0, 4);
    check_counters();

    // Byte write to the top lane
    bypass(32'h0000_2003, 1'b1, T_BYTE, 32'h0000_00AB, 1);
    check("byte_lane", lane_align(32'h0000_2003, T_BYTE, 32'h0000_00AB), 32'hAB00_0000);
    check_counters();

    // Flush on the second refill beat: line is not kept, FLUSH follows DONE
    cached_read(32'h0000_0200, 2, 1'b1);
    #1;
    check("flush_wait", {31'b0, core_wait}, 32'd1);
    repeat (2) @(posedge clk);
    cached_read(32'h0000_0200, -1, 1'b1);
    cached_read(32'h0000_1000, -1, 1'b1);
    check_counters();

    // Flush and request together on a resident line: flush wins, then miss
    cached_read(32'h0000_0204, 0, 1'b1);
    check_counters();

    // Reset in the middle of a refill
    @(negedge clk);
    core_req = 1'b1; core_addr = 32'h0000_0300; core_write = 1'b0; core_type = T_WORD;
    repeat (2) @(negedge clk);
    #1;
    check("midfill_I_req", {31'b0, I_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_I_req", {31'b0, I_req}, 32'd0);
    check("rst_mid_core_wait", {31'b0, core_wait}, 32'd0);
    @(negedge clk);
    core_req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    check_counters();
    cached_read(32'h0000_0300, -1, 1'b1);
    cached_read(32'h0000_0100, -1, 1'b1);
    check_counters();

    // Randomized mix under random memory stalls
    rand_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int kind;
      logic [31:0] a;
      logic [2:0] ty;
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        a = rand_cached_addr();
        cached_read(a, ($urandom_range(0, 15) == 0) ? 0 : -1, 1'b0);
      end else if (kind == 7) begin
        a = 32'h1000_0000 | (32'($urandom_range(0, 255)) << 2);
        bypass(a, 1'b0, T_WORD, 32'd0, -1);
      end else begin
        ty = 3'($urandom_range(0, 2));
        a = rand_cached_addr();
        if (ty == T_BYTE) a = a | 32'($urandom_range(0, 3));
        else if (ty == T_HWORD) a = a | (32'($urandom_range(0, 1)) << 1);
        bypass(a, 1'b1, ty, $urandom, -1);
      end
    end
    rand_en = 1'b0;
    repeat (2) @(posedge clk);
    check_counters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l1c_inst_sa.md
Name: l1c_inst_sa

Overview:
Parametrised N-way set-associative L1 instruction cache, successor to the direct-mapped instruction cache. Sits between the CPU fetch port and the AXI wrapper's instruction-side master port.
- Adds configurable ways, sets and line size.
- Adds critical-word-first wrapping refill and per-set round-robin replacement.
- Adds a flush (fence.i) input and hit/miss performance counters.
- Volatile/uncached accesses and core writes bypass the arrays as single-beat transfers.

Parameters:
WAYS, 2, associativity; power of 2, 1..8
SETS, 32, sets per way; power of 2
LINE_WORDS, 4, 32-bit words per line; power of 2, 2..16
VOL_BASE, 32'h1000_0000, base of uncached region
VOL_MASK, 32'hF000_0000, address bits compared against VOL_BASE; vol = ((core_addr & VOL_MASK) == VOL_BASE)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
core_req  in  1  fetch/access request; core_addr, core_write, core_in, core_type held stable while core_wait=1
core_addr  in  32  byte address
core_write  in  1  write access (always uncached pass-through)
core_in  in  32  write data
core_type  in  3  CACHE_BYTE/HWORD/WORD/BYTE_U/HWORD_U encoding from def.svh
core_out  out  32  read data; valid when core_req=1 and core_wait=0
core_wait  out  1  stall core
flush  in  1  single-cycle pulse; invalidate all lines
I_req  out  1  memory beat request
I_addr  out  32  memory beat address
I_write  out  1  memory write
I_in  out  32  memory write data, byte-lane aligned like the current cache
I_type  out  3  CACHE_WORD for refill; core_type for bypass
I_out  in  32  memory read data, valid when I_req=1 and I_wait=0
I_wait  in  1  memory stall; a beat completes on a cycle with I_req=1 and I_wait=0
hit_cnt  out  32  cached read hits, saturating
miss_cnt  out  32  cached read misses, saturating

Behaviour:
- Address split: offset = log2(LINE_WORDS)+2 bits, index = log2(SETS) bits, tag = remaining bits.
- Storage: valid/tag/data flop arrays and a per-set rr pointer of log2(WAYS) bits.
- Reset (rst_n low, async): all valid=0, all rr=0, state=IDLE, counters=0, flush_pend=0. Outputs: core_wait=0, core_out=0, I_req=0, I_addr=0, I_write=0, I_in=0.
- FSM states: IDLE, REFILL, DONE, BYPASS, FLUSH.
- IDLE, cached read, hit (any way valid with matching tag): core_wait=0 in the same cycle; core_out = word[core_addr offset] of the hit way; hit_cnt++.
- IDLE, cached read, miss: core_wait=1 -> REFILL; miss_cnt++ once per miss.
  - Victim = lowest-numbered invalid way, else rr[index]. Victim latched; rr[index]++ (wraps) when the line installs.
- IDLE, core_write or vol read: core_wait=1 -> BYPASS.
- REFILL: I_req=1, I_write=0, I_type=CACHE_WORD.
  - Beat k address = {tag,index,((crit+k) mod LINE_WORDS),2'b00}, crit = requested word. Address advances only on a completed beat.
  - Each beat writes the victim data word; beat 0 also latches core_out_reg.
  - After LINE_WORDS beats: write tag, set valid -> DONE.
- DONE: core_wait=0, core_out=core_out_reg for exactly one cycle -> IDLE. No counter update.
- BYPASS: one beat with I_addr=core_addr, I_write=core_write, I_type=core_type.
  - On completion: core_wait=0 that cycle; core_out=I_out for a read -> IDLE.
  - Arrays untouched. A write to a cached address is not snooped; software flushes.
- Flush:
  - flush in IDLE: -> FLUSH; core_wait=1 one cycle; all valid cleared; -> IDLE.
  - flush during REFILL/BYPASS/DONE: flush_pend=1. An in-progress refill completes its beats, then its valid is not set. FLUSH is entered after the transfer instead of IDLE; in the refill case it follows DONE.
- flush and core_req in the same IDLE cycle: flush wins; the request is re-evaluated after FLUSH and misses.
- core_req=0 in IDLE: no array/counter activity, core_wait=0.
- Counters saturate at 32'hFFFF_FFFF. Bypass accesses are not counted.
- Reset mid-refill: the partial line is discarded (valid cleared) and I_req drops immediately.

Test Plan:
- Cold read 0x0000_0108 (LINE_WORDS=4), I_wait=0 -> I_addr sequence 0x108,0x10C,0x100,0x104; core_wait high 5 cycles; core_out=first beat data; miss_cnt=1.
- Reread 0x0000_0100 then 0x0000_010C -> core_wait=0 same cycle both; hit_cnt=2; no I_req.
- WAYS=2: fill 0x000, 0x800, 0x1000 (same set) -> third evicts way0; 0x800 still hits, 0x000 misses.
- Read 0x1000_0004 (vol), I_wait=1 for 3 cycles -> single beat, core_wait released on beat completion, arrays/counters unchanged; write of BYTE 0xAB to 0x2003 -> I_in=0xAB00_0000, I_write=1.
- Flush pulse on 2nd refill beat -> refill finishes, then FLUSH; a reread of the same address misses.
- Assert rst_n low during REFILL -> I_req=0, core_wait=0 immediately; a subsequent read of that line misses.
